// File: rtl/conv_pe_sequencer_if.sv
// rtl/conv_pe_sequencer_if.sv - result channel of the convolution PE sequencer
// Ports: out_valid/out_ready handshake; out_psum signed result; out_row/out_col coordinates.
// master = sequencer (drives the result), slave = consumer (drives out_ready).
interface conv_pe_sequencer_if #(
    parameter int PSUM_DATA_WIDTH = 12,
    parameter int ROW_W           = 3,
    parameter int COL_W           = 3
) ();
    logic                              out_valid;
    logic                              out_ready;
    logic signed [PSUM_DATA_WIDTH-1:0] out_psum;
    logic [ROW_W-1:0]                  out_row;
    logic [COL_W-1:0]                  out_col;

    modport master (output out_valid, output out_psum, output out_row, output out_col, input out_ready);
    modport slave  (input out_valid, input out_psum, input out_row, input out_col, output out_ready);
endinterface

// File: rtl/conv_pe_sequencer.sv
// rtl/conv_pe_sequencer.sv - sequences a KxK binary-input convolution through one external PE
// Ports: clk/rst_n; start/busy/done frame control; w_wr_*/b_wr_* weight and bias config (IDLE only);
// ifm_rd_en/addr/data feature-map read (data one cycle after strobe); pe_* drive/return of the
// combinational PE; res (master) carries out_valid/out_ready/out_psum/out_row/out_col.
module conv_pe_sequencer #(
    parameter int DATA_WIDTH      = 8,
    parameter int PSUM_DATA_WIDTH = 12,
    parameter int KERNEL_SIZE     = 3,
    parameter int IMG_WIDTH       = 8,
    parameter int IMG_HEIGHT      = 8,
    localparam int NTAPS  = KERNEL_SIZE * KERNEL_SIZE,
    localparam int TAP_W  = (NTAPS > 1) ? $clog2(NTAPS) : 1,
    localparam int K_W    = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1,
    localparam int ADDR_W = $clog2(IMG_WIDTH * IMG_HEIGHT),
    localparam int ROW_W  = $clog2(IMG_HEIGHT),
    localparam int COL_W  = $clog2(IMG_WIDTH)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    output logic                              busy,
    output logic                              done,
    input  logic                              w_wr_en,
    input  logic [TAP_W-1:0]                  w_wr_addr,
    input  logic signed [DATA_WIDTH-1:0]      w_wr_data,
    input  logic                              b_wr_en,
    input  logic signed [DATA_WIDTH-1:0]      b_wr_data,
    output logic                              ifm_rd_en,
    output logic [ADDR_W-1:0]                 ifm_rd_addr,
    input  logic                              ifm_rd_data,
    output logic signed [PSUM_DATA_WIDTH-1:0] pe_inpsum,
    output logic signed [DATA_WIDTH-1:0]      pe_weight,
    output logic signed [DATA_WIDTH-1:0]      pe_bias,
    output logic                              pe_infmap_value,
    input  logic signed [PSUM_DATA_WIDTH-1:0] pe_outpsum,
    conv_pe_sequencer_if.master               res
);
    localparam int OH = IMG_HEIGHT - KERNEL_SIZE + 1;
    localparam int OW = IMG_WIDTH - KERNEL_SIZE + 1;

    typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_LAST, S_OUT} state_e;

    state_e                              state_q, state_d;
    logic [ROW_W-1:0]                    row_q, row_d, out_row_q, out_row_d;
    logic [COL_W-1:0]                    col_q, col_d, out_col_q, out_col_d;
    logic [TAP_W-1:0]                    tap_q, tap_d;
    logic [K_W-1:0]                      ky_q, ky_d, kx_q, kx_d;
    logic signed [PSUM_DATA_WIDTH-1:0]   acc_q, acc_d, out_psum_q, out_psum_d;
    logic signed [DATA_WIDTH-1:0]        weight_q [NTAPS];
    logic signed [DATA_WIDTH-1:0]        weight_d [NTAPS];
    logic signed [DATA_WIDTH-1:0]        bias_q, bias_d;
    logic                                done_q, done_d;
    logic                                acc_en;
    logic                                last_pixel;
    logic [TAP_W-1:0]                    acc_tap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            row_q      <= '0;
            col_q      <= '0;
            tap_q      <= '0;
            ky_q       <= '0;
            kx_q       <= '0;
            acc_q      <= '0;
            out_psum_q <= '0;
            out_row_q  <= '0;
            out_col_q  <= '0;
            bias_q     <= '0;
            done_q     <= 1'b0;
            for (int i = 0; i < NTAPS; i++) weight_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            tap_q      <= tap_d;
            ky_q       <= ky_d;
            kx_q       <= kx_d;
            acc_q      <= acc_d;
            out_psum_q <= out_psum_d;
            out_row_q  <= out_row_d;
            out_col_q  <= out_col_d;
            bias_q     <= bias_d;
            done_q     <= done_d;
            for (int i = 0; i < NTAPS; i++) weight_q[i] <= weight_d[i];
        end
    end

    always_comb begin
        state_d         = state_q;
        row_d           = row_q;
        col_d           = col_q;
        tap_d           = tap_q;
        ky_d            = ky_q;
        kx_d            = kx_q;
        acc_d           = acc_q;
        out_psum_d      = out_psum_q;
        out_row_d       = out_row_q;
        out_col_d       = out_col_q;
        weight_d        = weight_q;
        bias_d          = bias_q;
        done_d          = 1'b0;
        ifm_rd_en       = 1'b0;
        ifm_rd_addr     = '0;
        pe_inpsum       = '0;
        pe_weight       = '0;
        pe_bias         = '0;
        pe_infmap_value = 1'b0;

        // The PE consumes the pixel read one cycle earlier, so the tap being
        // accumulated lags the read tap by one; LAST finishes the final tap.
        acc_en     = ((state_q == S_COMPUTE) && (tap_q != '0)) || (state_q == S_LAST);
        acc_tap    = (state_q == S_LAST) ? TAP_W'(NTAPS - 1) : (tap_q - TAP_W'(1));
        last_pixel = (row_q == ROW_W'(OH - 1)) && (col_q == COL_W'(OW - 1));

        if (acc_en) begin
            pe_weight       = weight_q[acc_tap];
            pe_infmap_value = ifm_rd_data;
            // Tap 0 restarts the sum and carries the bias, so bias lands once per pixel.
            if (acc_tap == '0) pe_bias = bias_q;
            else               pe_inpsum = acc_q;
            acc_d = pe_outpsum;
        end

        case (state_q)
            S_IDLE: begin
                if (w_wr_en && (w_wr_addr < TAP_W'(NTAPS))) weight_d[w_wr_addr] = w_wr_data;
                if (b_wr_en) bias_d = b_wr_data;
                if (start) begin
                    state_d = S_COMPUTE;
                    row_d   = '0;
                    col_d   = '0;
                    tap_d   = '0;
                    ky_d    = '0;
                    kx_d    = '0;
                end
            end
            S_COMPUTE: begin
                ifm_rd_en   = 1'b1;
                ifm_rd_addr = ADDR_W'((int'(row_q) + int'(ky_q)) * IMG_WIDTH + int'(col_q) + int'(kx_q));
                if (tap_q == TAP_W'(NTAPS - 1)) begin
                    state_d = S_LAST;
                end else begin
                    tap_d = tap_q + TAP_W'(1);
                    if (kx_q == K_W'(KERNEL_SIZE - 1)) begin
                        kx_d = '0;
                        ky_d = ky_q + K_W'(1);
                    end else begin
                        kx_d = kx_q + K_W'(1);
                    end
                end
            end
            S_LAST: begin
                out_psum_d = pe_outpsum;
                out_row_d  = row_q;
                out_col_d  = col_q;
                state_d    = S_OUT;
            end
            S_OUT: begin
                if (res.out_ready) begin
                    tap_d = '0;
                    ky_d  = '0;
                    kx_d  = '0;
                    if (last_pixel) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_COMPUTE;
                        if (col_q == COL_W'(OW - 1)) begin
                            col_d = '0;
                            row_d = row_q + ROW_W'(1);
                        end else begin
                            col_d = col_q + COL_W'(1);
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy          = (state_q != S_IDLE);
    assign done          = done_q;
    assign res.out_valid = (state_q == S_OUT);
    assign res.out_psum  = out_psum_q;
    assign res.out_row   = out_row_q;
    assign res.out_col   = out_col_q;
endmodule

// File: tb/tb_conv_pe_sequencer.sv
// tb/tb_conv_pe_sequencer.sv - directed self-checking bench for conv_pe_sequencer
module tb_conv_pe_sequencer;
    logic              clk = 1'b0;
    logic              rst_n;
    logic              start, busy, done;
    logic              w_wr_en, b_wr_en;
    logic [3:0]        w_wr_addr;
    logic signed [7:0] w_wr_data, b_wr_data;
    logic              ifm_rd_en, ifm_rd_data;
    logic [5:0]        ifm_rd_addr;
    logic signed [11:0] pe_inpsum, pe_outpsum;
    logic signed [7:0] pe_weight, pe_bias;
    logic              pe_infmap_value;
    logic              ifm_mem [64];
    int                n_cmp = 0;
    int                n_bad = 0;

    conv_pe_sequencer_if #(.PSUM_DATA_WIDTH(12), .ROW_W(3), .COL_W(3)) res_if ();

    conv_pe_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data),
        .b_wr_en(b_wr_en), .b_wr_data(b_wr_data),
        .ifm_rd_en(ifm_rd_en), .ifm_rd_addr(ifm_rd_addr), .ifm_rd_data(ifm_rd_data),
        .pe_inpsum(pe_inpsum), .pe_weight(pe_weight), .pe_bias(pe_bias),
        .pe_infmap_value(pe_infmap_value), .pe_outpsum(pe_outpsum),
        .res(res_if)
    );

    always #5 clk = ~clk;

    // External PE: inpsum + weight*(bit ? +1 : -1) + bias, all sign-extended to 12 bits.
    always_comb begin
        logic signed [11:0] w_ext, b_ext;
        w_ext = {{4{pe_weight[7]}}, pe_weight};
        b_ext = {{4{pe_bias[7]}}, pe_bias};
        pe_outpsum = pe_inpsum + (pe_infmap_value ? w_ext : -w_ext) + b_ext;
    end

    always @(posedge clk) ifm_rd_data <= ifm_rd_en ? ifm_mem[ifm_rd_addr] : 1'b0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_weight(input int t, input int v);
        w_wr_en = 1'b1; w_wr_addr = 4'(t); w_wr_data = 8'(v);
        tick();
        w_wr_en = 1'b0;
    endtask

    task automatic wr_bias(input int v);
        b_wr_en = 1'b1; b_wr_data = 8'(v);
        tick();
        b_wr_en = 1'b0;
    endtask

    task automatic fill_map(input logic v);
        for (int i = 0; i < 64; i++) ifm_mem[i] = v;
    endtask

    task automatic all_weights(input int v);
        for (int t = 0; t < 9; t++) wr_weight(t, v);
    endtask

    // Runs a full frame with out_ready high; every result equals exp_base except
    // raster index exc_idx which must equal exc_val. disturb pokes start and
    // config writes while busy.
    task automatic run_frame(input string name, input int exp_base, input int exc_idx,
                             input int exc_val, input bit disturb);
        int n, cyc, dones, first_rd, last_valid, exp;
        n = 0; cyc = 0; dones = 0; first_rd = -1; last_valid = -1;
        res_if.out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (n < 36 && cyc < 1000) begin
            if (disturb && cyc == 3) begin
                start = 1'b1; w_wr_en = 1'b1; w_wr_addr = 4'd0; w_wr_data = 8'sd5;
                b_wr_en = 1'b1; b_wr_data = 8'sd7;
            end else begin
                start = 1'b0; w_wr_en = 1'b0; b_wr_en = 1'b0;
            end
            if (ifm_rd_en && first_rd < 0) first_rd = cyc;
            if (done) dones++;
            if (res_if.out_valid) begin
                exp = (n == exc_idx) ? exc_val : exp_base;
                chk({name, " psum"}, int'(res_if.out_psum), exp);
                chk({name, " row"}, int'(res_if.out_row), n / 6);
                chk({name, " col"}, int'(res_if.out_col), n % 6);
                if (n == 0) chk({name, " latency"}, cyc - first_rd, 10);
                else        chk({name, " period"}, cyc - last_valid, 11);
                last_valid = cyc;
                n++;
            end
            tick();
            cyc++;
        end
        start = 1'b0; w_wr_en = 1'b0; b_wr_en = 1'b0;
        chk({name, " results"}, n, 36);
        for (int i = 0; i < 4; i++) begin
            if (done) dones++;
            tick();
        end
        chk({name, " done count"}, dones, 1);
        chk({name, " idle busy"}, int'(busy), 0);
    endtask

    initial begin
        int n, cyc;
        rst_n = 1'b0; start = 1'b0; w_wr_en = 1'b0; b_wr_en = 1'b0;
        w_wr_addr = '0; w_wr_data = '0; b_wr_data = '0;
        res_if.out_ready = 1'b1;
        fill_map(1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset out_valid", int'(res_if.out_valid), 0);
        chk("reset rd_en", int'(ifm_rd_en), 0);
        chk("reset psum", int'(res_if.out_psum), 0);
        rst_n = 1'b1;
        tick();

        // All ones, unit weights, no bias: every window sums to 9.
        fill_map(1'b1);
        all_weights(1);
        wr_bias(0);
        run_frame("ones", 9, -1, 0, 1'b0);

        // All zeros with bias 5: -9 + 5.
        fill_map(1'b0);
        wr_bias(5);
        run_frame("bias", -4, -1, 0, 1'b0);

        // Weights 0..8 by tap: sum 36; pixel (0,0) low only touches tap 0 (weight 0).
        wr_bias(0);
        for (int t = 0; t < 9; t++) wr_weight(t, t);
        fill_map(1'b1);
        run_frame("ramp", 36, -1, 0, 1'b0);
        ifm_mem[0] = 1'b0;
        run_frame("ramp p00", 36, -1, 0, 1'b0);
        // Pixel (0,1) low is tap 1 of output (0,0) -> 36 - 2, tap 0 of (0,1) -> unchanged.
        fill_map(1'b1);
        ifm_mem[1] = 1'b0;
        run_frame("ramp p01", 36, 0, 34, 1'b0);

        // Backpressure on the first result.
        fill_map(1'b1);
        all_weights(1);
        res_if.out_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (!res_if.out_valid && cyc < 100) begin tick(); cyc++; end
        chk("stall reach valid", int'(res_if.out_valid), 1);
        for (int i = 0; i < 4; i++) begin
            chk("stall valid", int'(res_if.out_valid), 1);
            chk("stall psum", int'(res_if.out_psum), 9);
            chk("stall row", int'(res_if.out_row), 0);
            chk("stall col", int'(res_if.out_col), 0);
            chk("stall rd_en", int'(ifm_rd_en), 0);
            tick();
        end
        res_if.out_ready = 1'b1;
        tick();
        res_if.out_ready = 1'b0;
        chk("stall release valid", int'(res_if.out_valid), 0);
        cyc = 0;
        while (!res_if.out_valid && cyc < 100) begin tick(); cyc++; end
        chk("stall next psum", int'(res_if.out_psum), 9);
        chk("stall next row", int'(res_if.out_row), 0);
        chk("stall next col", int'(res_if.out_col), 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        res_if.out_ready = 1'b1;

        // Reset during COMPUTE of pixel (2,3).
        all_weights(1);
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0; cyc = 0;
        while (n < 15 && cyc < 1000) begin
            if (res_if.out_valid) n++;
            tick();
            cyc++;
        end
        chk("abort first addr", int'(ifm_rd_addr), 19);
        repeat (3) tick();
        chk("abort tap3 addr", int'(ifm_rd_addr), 27);
        #2 rst_n = 1'b0;
        #1;
        chk("abort busy", int'(busy), 0);
        chk("abort done", int'(done), 0);
        chk("abort out_valid", int'(res_if.out_valid), 0);
        chk("abort rd_en", int'(ifm_rd_en), 0);
        chk("abort psum", int'(res_if.out_psum), 0);
        chk("abort row", int'(res_if.out_row), 2 * 0);
        chk("abort col", int'(res_if.out_col), 0);
        chk("abort pe_weight", int'(pe_weight), 0);
        chk("abort pe_inpsum", int'(pe_inpsum), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk("abort no done", int'(done), 0);
        // Weights and bias were cleared by reset.
        run_frame("post-reset zero w", 0, -1, 0, 1'b0);
        all_weights(1);
        run_frame("restart", 9, -1, 0, 1'b0);

        // start and config writes while busy must be ignored.
        run_frame("busy writes", 9, -1, 0, 1'b1);
        run_frame("after busy writes", 9, -1, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/conv_pe_sequencer.md
CONV_PE_SEQUENCER -- requirements
Module: conv_pe_sequencer

Interface
REQ-001 Parameters SHALL be (name, default, meaning): DATA_WIDTH, 8, weight/bias width; PSUM_DATA_WIDTH, 12, partial-sum width; KERNEL_SIZE, 3, kernel edge K; IMG_WIDTH, 8, input map width W; IMG_HEIGHT, 8, input map height H.
REQ-002 Ports SHALL be (name direction width meaning): clk in 1 clock; rst_n in 1 async active-low reset; start in 1 begin-frame pulse; busy out 1 frame in progress; done out 1 frame-complete pulse.
REQ-003 Config ports SHALL be: w_wr_en in 1 weight write; w_wr_addr in clog2(K*K) tap index; w_wr_data in DATA_WIDTH signed weight; b_wr_en in 1 bias write; b_wr_data in DATA_WIDTH signed bias.
REQ-004 Feature-map ports SHALL be: ifm_rd_en out 1 read strobe; ifm_rd_addr out clog2(W*H) pixel index; ifm_rd_data in 1 binary pixel, valid the cycle after ifm_rd_en.
REQ-005 PE ports SHALL be: pe_inpsum out PSUM_DATA_WIDTH; pe_weight out DATA_WIDTH; pe_bias out DATA_WIDTH; pe_infmap_value out 1; pe_outpsum in PSUM_DATA_WIDTH (combinational inpsum + weight*(bit?+1:-1) + bias).
REQ-006 Output ports SHALL be: out_valid out 1; out_ready in 1; out_psum out PSUM_DATA_WIDTH signed result; out_row out clog2(H) and out_col out clog2(W) output coordinates.
REQ-007 Clock SHALL be clk only; reset rst_n SHALL be asynchronous, active-low.

Function
REQ-008 Output map SHALL be OH=H-K+1 by OW=W-K+1, valid convolution, stride 1, raster order (col fastest).
REQ-009 Weights SHALL be K*K internal registers, tap t=ky*K+kx, written when w_wr_en=1 in IDLE only; bias register written when b_wr_en=1 in IDLE only; writes outside IDLE ignored.
REQ-010 FSM states SHALL be IDLE, COMPUTE, LAST, OUT.
REQ-011 IDLE: start=1 -> COMPUTE, row=col=0, tap=0; start while not IDLE ignored.
REQ-012 COMPUTE SHALL last exactly K*K cycles; in tap cycle t: ifm_rd_en=1, ifm_rd_addr=(row+ky)*W+(col+kx); after t=K*K-1 -> LAST.
REQ-013 In the cycle after a tap-t read (COMPUTE cycles t>=1 and LAST), PE SHALL be driven pe_weight=weight[t], pe_infmap_value=ifm_rd_data, pe_inpsum=0 and pe_bias=bias if t=0, else pe_inpsum=acc and pe_bias=0; acc<=pe_outpsum.
REQ-014 Bias SHALL be applied exactly once per output pixel.
REQ-015 LAST SHALL accumulate tap K*K-1, load out_psum<=pe_outpsum, out_row/out_col<=row/col, -> OUT.
REQ-016 OUT: out_valid=1; out_psum/out_row/out_col SHALL be stable while out_valid=1 and out_ready=0; no ifm reads in OUT.
REQ-017 OUT with out_ready=1: out_valid deasserts next cycle; if (row,col) is last pixel -> IDLE with done=1 for one cycle; else advance col (wrap to 0, row+1 at OW-1) and -> COMPUTE.
REQ-018 Per-pixel latency SHALL be K*K+1 cycles from first read to out_valid; throughput K*K+2 cycles/pixel with out_ready held 1.
REQ-019 Arithmetic SHALL be signed two's complement, accumulate wraps modulo 2^PSUM_DATA_WIDTH, no saturation.
REQ-020 busy SHALL be 1 in every state except IDLE.
REQ-021 ifm_rd_en=0 and PE inputs SHALL be 0 in IDLE and OUT.

Reset
REQ-022 rst_n=0 SHALL immediately force IDLE; busy, done, out_valid, ifm_rd_en=0; out_psum, out_row, out_col, acc, counters=0; weights and bias=0.
REQ-023 Reset mid-frame SHALL abort without emitting done or a partial result; a new start after release SHALL begin at pixel (0,0).

Verification
REQ-024 All weights=1, bias=0, map all ones, start -> 36 results each out_psum=9, first out_valid 10 cycles after first ifm_rd_en, done once after 36th handshake.
REQ-025 All weights=1, bias=5, map all zeros -> every out_psum=-4 (-9+5).
REQ-026 Weights 0..8 by tap, bias=0, map all ones -> out_psum=36; pixel (0,0) only =0 with rest ones -> out_psum=36-0=36, pixel (0,1)=0 -> (0,0) result 34.
REQ-027 out_ready=0 for 4 cycles at first result -> out_valid held, out_psum/out_row/out_col unchanged, ifm_rd_en=0, then one handshake advances to (0,1).
REQ-028 rst_n pulsed low during COMPUTE of pixel (2,3) -> all outputs 0 same cycle; restart yields full 36 results from (0,0).
REQ-029 start and w_wr_en asserted while busy -> ignored; results match pre-frame weights.
